// File: rtl/regfile_dump.sv
// Debug read-out engine: freezes the core via a stall handshake, then streams
// every register file word with its index over a valid/ready interface.
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              stall_req,
  input  logic              stall_ack,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_ACK = 3'd1,
    READ     = 3'd2,
    SEND     = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   idx, idx_next;
  logic                stall_next;
  logic                valid_next;
  logic                last_next;
  logic [DATA_W-1:0]   data_next;
  logic [ADDR_W-1:0]   index_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      stall_req <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      stall_req <= stall_next;
      out_valid <= valid_next;
      out_last  <= last_next;
      out_data  <= data_next;
      out_index <= index_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    stall_next = stall_req;
    valid_next = out_valid;
    last_next  = out_last;
    data_next  = out_data;
    index_next = out_index;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = WAIT_ACK;
          idx_next   = '0;
          stall_next = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (stall_ack) state_next = READ;
      end
      READ: begin
        data_next  = dbg_data;
        index_next = idx;
        valid_next = 1'b1;
        last_next  = (idx == LAST_IDX);
        state_next = SEND;
      end
      SEND: begin
        // Last-index test comes first so idx never wraps past NUM_REGS-1.
        if (out_ready) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          if (idx == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next   = idx + ADDR_W'(1);
            state_next = READ;
          end
        end
      end
      DONE: begin
        stall_next = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Abort overrides everything, including a same-cycle handshake.
    if (abort && state != IDLE) begin
      state_next = IDLE;
      idx_next   = '0;
      stall_next = 1'b0;
      valid_next = 1'b0;
      last_next  = 1'b0;
    end
  end

  assign dbg_addr = (state == READ) ? idx : '0;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized and directed bench for regfile_dump; a transaction-level
// scoreboard checks every cycle, directed tests pin timing and literals.
module tb_regfile_dump;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic              stall_req;
  logic              stall_ack;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] regs [NUM_REGS];

  int total = 0;
  int bad   = 0;

  // scoreboard state
  int  cyc = 0;
  int  exp_idx = 0;
  int  words = 0;
  int  done_count = 0;
  int  last_count = 0;
  int  t_first = 0;
  int  t_done = 0;
  bit  mon_en = 0;
  bit  p_hold = 0;
  bit  p_valid = 0;
  logic [DATA_W-1:0] p_data;
  logic [ADDR_W-1:0] p_index;

  regfile_dump #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .stall_req(stall_req), .stall_ack(stall_ack),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign dbg_data = regs[dbg_addr];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting, got nothing expected event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every cycle: delivered words must be in order, equal to the register
  // contents, held stable under backpressure; done only after all words.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (p_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, p_data);
        check("hold_index", out_index, p_index);
      end
      if (out_valid) begin
        check("word_index", out_index, exp_idx);
        check("word_data", out_data, regs[out_index]);
        check("word_last", out_last, out_index == NUM_REGS - 1);
        check("addr_idle_in_send", dbg_addr, 0);
        if (!p_valid && out_index == 0) t_first = cyc;
      end else begin
        check("last_without_valid", out_last, 0);
      end
      check("busy_eq_stall", busy, stall_req);
      if (dbg_addr != 0) check("read_addr", dbg_addr, exp_idx);
      if (done) begin
        check("done_after_all", exp_idx, NUM_REGS);
        done_count++;
        t_done = cyc;
      end
      p_hold = 0;
      if (reset || (abort && busy) || done) begin
        exp_idx = 0;
      end else if (out_valid && out_ready) begin
        words++;
        if (out_last) last_count++;
        exp_idx++;
      end else if (out_valid) begin
        p_hold = 1;
      end
      p_valid = out_valid;
      p_data  = out_data;
      p_index = out_index;
    end
  end

  task automatic wait_done(input string name, input int bound);
    int d0 = done_count;
    int c = 0;
    while (done_count == d0 && c < bound) begin
      tick();
      c++;
    end
    if (done_count == d0) timeout(name);
  endtask

  task automatic wait_index(input string name, input int k, input int bound);
    int c = 0;
    while (!(out_valid && out_index == k) && c < bound) begin
      tick();
      c++;
    end
    if (!(out_valid && out_index == k)) timeout(name);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_index"}, out_index, 0);
    check({tag, "_stall"}, stall_req, 0);
    check({tag, "_addr"}, dbg_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic begin_dump();
    start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    int w0, d0, ld0, abort_at, c;
    bit aborted;
    reset = 1; start = 0; abort = 0; stall_ack = 0; out_ready = 0;
    for (int r = 0; r < NUM_REGS; r++) regs[r] = DATA_W'(r);
    tick(); tick();
    reset = 0;
    check_reset_vals("rst");
    mon_en = 1;

    // T1: full dump with ready held high, xN = N
    w0 = words; d0 = done_count; ld0 = last_count;
    out_ready = 1;
    begin_dump();
    check("t1_stall_rise", stall_req, 1);
    check("t1_busy", busy, 1);
    tick();
    stall_ack = 1;
    wait_done("t1_done", 300);
    stall_ack = 0;
    check("t1_words", words - w0, 32);
    check("t1_dones", done_count - d0, 1);
    check("t1_last_once", last_count - ld0, 1);
    check("t1_read_to_done", t_done - t_first + 1, 64);
    check("t1_stall_drop", stall_req, 0);
    check("t1_idle", busy, 0);

    // T2: backpressure on index 5
    regs[5] = 32'hDEADBEEF;
    w0 = words;
    begin_dump();
    stall_ack = 1;
    wait_index("t2_idx5", 5, 100);
    out_ready = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_bp_valid", out_valid, 1);
      check("t2_bp_data", out_data, 32'hDEADBEEF);
      check("t2_bp_index", out_index, 5);
    end
    out_ready = 1;
    tick(); tick();
    check("t2_next_valid", out_valid, 1);
    check("t2_next_index", out_index, 6);
    wait_done("t2_done", 300);
    stall_ack = 0;
    check("t2_words", words - w0, 32);
    regs[5] = 32'd5;

    // T3: ack delayed by 7 cycles
    begin_dump();
    for (int i = 0; i < 7; i++) begin
      check("t3_no_valid", out_valid, 0);
      check("t3_addr0", dbg_addr, 0);
      check("t3_busy", busy, 1);
      tick();
    end
    stall_ack = 1;
    tick();
    check("t3_ack1_valid", out_valid, 0);
    stall_ack = 0;
    tick();
    check("t3_ack2_valid", out_valid, 1);
    check("t3_ack2_index", out_index, 0);
    wait_done("t3_done", 300);

    // T4: abort in SEND at index 12 with same-cycle handshake
    for (int r = 1; r < NUM_REGS; r++) regs[r] = $urandom;
    d0 = done_count;
    begin_dump();
    stall_ack = 1;
    wait_index("t4_idx12", 12, 100);
    abort = 1;
    tick();
    abort = 0;
    stall_ack = 0;
    check("t4_valid", out_valid, 0);
    check("t4_stall", stall_req, 0);
    check("t4_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_quiet", out_valid, 0);
    end
    check("t4_no_done", done_count - d0, 0);
    w0 = words;
    begin_dump();
    stall_ack = 1;
    tick(); tick();
    check("t4_restart_index", out_index, 0);
    wait_done("t4_done", 300);
    stall_ack = 0;
    check("t4_restart_words", words - w0, 32);

    // T5: reset mid-dump at index 20, then a start pulsed mid-dump is ignored
    begin_dump();
    stall_ack = 1;
    wait_index("t5_idx20", 20, 100);
    reset = 1;
    tick();
    reset = 0;
    stall_ack = 0;
    check_reset_vals("t5_rst");
    w0 = words; d0 = done_count;
    begin_dump();
    stall_ack = 1;
    wait_index("t5_idx10", 10, 100);
    start = 1;
    tick();
    start = 0;
    wait_done("t5_done", 300);
    stall_ack = 0;
    repeat (5) tick();
    check("t5_words", words - w0, 32);
    check("t5_single_done", done_count - d0, 1);

    // Randomized dumps: random data, ack delay and ready; one random abort
    for (int n = 0; n < 6; n++) begin
      for (int r = 1; r < NUM_REGS; r++) regs[r] = $urandom;
      d0 = done_count;
      begin_dump();
      repeat ($urandom_range(0, 5)) tick();
      stall_ack = 1;
      aborted = 0;
      abort_at = $urandom_range(10, 60);
      c = 0;
      while (done_count == d0 && !aborted && c < 2000) begin
        out_ready = 1'($urandom_range(0, 1));
        if (n == 5 && c == abort_at) begin
          abort = 1;
          tick();
          abort = 0;
          aborted = 1;
          check("rnd_abort_busy", busy, 0);
        end else begin
          tick();
        end
        c++;
      end
      stall_ack = 0;
      out_ready = 1;
      if (!aborted && done_count == d0) timeout("rnd_done");
      repeat (3) tick();
      check("rnd_idle", busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
